// File: rtl/dec_pkg.sv
// -----------------------------------------------------------------------------
// dec_pkg
// Shared widths and types for the registered 4-to-16 one-hot decoder.
//
// Contents:
//   CODE_W      width of the binary code (4)
//   OUT_W       width of the one-hot select vector (16)
//   SLICE_W     width of one 3-to-8 decoder slice (8)
//   onehot16_t  ascending-index one-hot vector, element 0 is the leftmost bit
//   onehot16()  returns the one-hot vector for a code, with element [code] set
// -----------------------------------------------------------------------------
package dec_pkg;

    localparam int CODE_W  = 4;
    localparam int OUT_W   = 16;
    localparam int SLICE_W = 8;

    typedef logic [0:OUT_W-1] onehot16_t;

    // Reference decode: sets the single element matching the code.
    function automatic onehot16_t onehot16(input logic [CODE_W-1:0] code);
        onehot16_t result;
        result       = '0;
        result[code] = 1'b1;
        return result;
    endfunction

endpackage : dec_pkg

// File: rtl/dec3_8.sv
// -----------------------------------------------------------------------------
// dec3_8
// Purely combinational 3-to-8 one-hot decoder slice with enable.
//
// Ports:
//   a     [2:0]  binary code for this slice
//   en_s         slice enable; when low every output is zero
//   out   [0:7]  one-hot output, out[j] = en_s & (a == j)
// -----------------------------------------------------------------------------
module dec3_8
    import dec_pkg::*;
(
    input  logic [2:0]         a,
    input  logic               en_s,
    output logic [0:SLICE_W-1] out
);

    always_comb begin
        out = '0;
        for (int j = 0; j < SLICE_W; j++) begin
            out[j] = en_s & (a == 3'(j));
        end
    end

endmodule : dec3_8

// File: rtl/dec4_16_reg.sv
// -----------------------------------------------------------------------------
// dec4_16_reg
// Registered 4-to-16 one-hot decoder with enable, built from two dec3_8
// slices. The code MSB steers the enable to either the low or the high slice,
// so at most one output bit is ever set. Output appears one clock after the
// code is sampled.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous, active-low reset (clears d and valid immediately)
//   en     decode enable; low forces an all-zero decode
//   i      [3:0]  binary code
//   d      [0:15] registered one-hot select, d[0] is the leftmost bit
//   valid  registered copy of en
// -----------------------------------------------------------------------------
module dec4_16_reg
    import dec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [CODE_W-1:0] i,
    output onehot16_t         d,
    output logic              valid
);

    logic [0:SLICE_W-1] lo_slice;
    logic [0:SLICE_W-1] hi_slice;
    logic               lo_en;
    logic               hi_en;
    onehot16_t          d_d;
    onehot16_t          d_q;
    logic               valid_q;

    // i[3] picks exactly one slice; the other stays fully idle.
    assign lo_en = en & ~i[3];
    assign hi_en = en &  i[3];

    dec3_8 u_slice_lo (
        .a    (i[2:0]),
        .en_s (lo_en),
        .out  (lo_slice)
    );

    dec3_8 u_slice_hi (
        .a    (i[2:0]),
        .en_s (hi_en),
        .out  (hi_slice)
    );

    // Low slice fills d[0:7], high slice fills d[8:15].
    assign d_d = {lo_slice, hi_slice};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            d_q     <= d_d;
            valid_q <= en;
        end
    end

    assign d     = d_q;
    assign valid = valid_q;

endmodule : dec4_16_reg

// File: tb/tb_dec4_16_reg.sv
// -----------------------------------------------------------------------------
// tb_dec4_16_reg
// Scoreboard bench for dec4_16_reg: the driver pushes the expected {valid, d}
// for every code it presents, and an independent monitor pops and compares one
// entry after each rising edge. Reset behaviour is checked directly.
// -----------------------------------------------------------------------------
module tb_dec4_16_reg;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  i;
    logic [0:15] d;
    logic        valid;

    int errorCount = 0;
    int checkCount = 0;

    // Each entry holds {valid, d} expected one edge after the stimulus.
    logic [16:0] sbQ[$];

    dec4_16_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .i     (i),
        .d     (d),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the selected code lights the element counted from the left;
    // disabled decodes are all zero.
    function automatic logic [0:15] refDecode(input logic e, input logic [3:0] c);
        logic [0:15] r;
        r = 16'h0000;
        if (e) r = 16'h8000 >> c;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic gotV, input logic [0:15] gotD,
                               input logic expV, input logic [0:15] expD);
        checkCount++;
        if (gotV !== expV || gotD !== expD) begin
            errorCount++;
            $display("[TB] FAIL %s: got valid=%0b d=%h, expected valid=%0b d=%h",
                     name, gotV, gotD, expV, expD);
        end
    endtask

    // Present one code on the falling edge and record what must appear after
    // the next rising edge.
    task automatic applyStimulus(input logic e, input logic [3:0] c);
        @(negedge clk);
        en = e;
        i  = c;
        sbQ.push_back({e, refDecode(e, c)});
    endtask

    // Monitor: samples just after each rising edge and retires one entry.
    initial begin
        logic [16:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (sbQ.size() > 0) begin
                exp = sbQ.pop_front();
                checkOutput("scoreboard", valid, d, exp[16], exp[15:0]);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        i     = 4'h0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", valid, d, 1'b0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Full sweep with enable high.
        for (int k = 0; k < 16; k++) applyStimulus(1'b1, 4'(k));

        // Slice boundary.
        applyStimulus(1'b1, 4'd7);
        applyStimulus(1'b1, 4'd8);

        // Enable gating, then the same code enabled.
        applyStimulus(1'b0, 4'hA);
        applyStimulus(1'b1, 4'hA);

        // Wrap-around, back-to-back.
        applyStimulus(1'b1, 4'hF);
        applyStimulus(1'b1, 4'h0);
        applyStimulus(1'b1, 4'hF);
        applyStimulus(1'b1, 4'h0);

        // Asynchronous reset with bit 7 showing.
        applyStimulus(1'b1, 4'd7);
        @(posedge clk);
        #3;
        checkOutput("pre_reset", valid, d, 1'b1, 16'h0100);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", valid, d, 1'b0, 16'h0000);

        // Inputs sampled during reset are discarded.
        @(negedge clk);
        en = 1'b1;
        i  = 4'd5;
        @(posedge clk);
        #1;
        checkOutput("reset_holds", valid, d, 1'b0, 16'h0000);

        // Release between edges: output stays clear until the next rising edge.
        @(negedge clk);
        en = 1'b1;
        i  = 4'd3;
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("release_pre_edge", valid, d, 1'b0, 16'h0000);
        sbQ.push_back({1'b1, refDecode(1'b1, 4'd3)});

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 4'($urandom));
        end

        // Reset mid-stream: the in-flight code is lost.
        applyStimulus(1'b1, 4'd9);
        #2;
        rst_n = 1'b0;
        void'(sbQ.pop_back());
        #1;
        checkOutput("midstream_reset", valid, d, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("inflight_lost", valid, d, 1'b0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        sbQ.push_back({1'b1, refDecode(1'b1, 4'd9)});
        applyStimulus(1'b0, 4'd9);

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 10; w++) begin
            if (sbQ.size() == 0) break;
            @(posedge clk);
            #2;
        end
        checkCount++;
        if (sbQ.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sbQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule : tb_dec4_16_reg
